// File: rtl/gate_seq_arbiter.sv
// Round-robin arbiter that time-shares one 1-bit gate slice between two requesters,
// evaluating WIDTH-bit bitwise ops LSB first and returning the result on a valid/ready channel.
module gate_seq_arbiter #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [1:0]       req0_op,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [1:0]       req1_op,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic             rsp_id,
  output logic [WIDTH-1:0] rsp_data,
  output logic             gate_en,
  output logic [1:0]       gate_op,
  output logic             gate_a,
  output logic             gate_b,
  input  logic             gate_out
);

  localparam int IW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state;
  logic [IW-1:0]    idx;
  logic [WIDTH-1:0] a_q, b_q, result;
  logic [1:0]       op_q;
  logic             rr_last, owner;
  logic             grant0, grant1;

  // rr_last names the previous winner; on contention the other side wins.
  // rst_n is folded in so ready is forced low while reset is held.
  always_comb begin
    grant0 = 1'b0;
    grant1 = 1'b0;
    if (rst_n && state == IDLE) begin
      grant0 = req0_valid && (!req1_valid || rr_last);
      grant1 = req1_valid && (!req0_valid || !rr_last);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      idx     <= '0;
      a_q     <= '0;
      b_q     <= '0;
      op_q    <= 2'b00;
      result  <= '0;
      rr_last <= 1'b1;
      owner   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (grant0 || grant1) begin
            op_q    <= grant1 ? req1_op : req0_op;
            a_q     <= grant1 ? req1_a  : req0_a;
            b_q     <= grant1 ? req1_b  : req0_b;
            rr_last <= grant1;
            owner   <= grant1;
            idx     <= '0;
            result  <= '0;
            state   <= RUN;
          end
        end
        RUN: begin
          result[idx] <= gate_out;
          if (idx == IW'(WIDTH - 1)) begin
            state <= DONE;
          end else begin
            idx <= idx + 1'b1;
          end
        end
        DONE: begin
          if (rsp_ready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign req0_ready = grant0;
  assign req1_ready = grant1;

  assign gate_en  = (state == RUN);
  assign gate_op  = gate_en ? op_q : 2'b00;
  assign gate_a   = gate_en & a_q[idx];
  assign gate_b   = gate_en & b_q[idx];

  assign rsp_valid = (state == DONE);
  assign rsp_data  = result;
  assign rsp_id    = owner;

endmodule

// File: tb/tb_gate_seq_arbiter.sv
// Directed bench for gate_seq_arbiter: vector table for arbitration/results,
// hand sequences for backpressure, mid-op reset and a WIDTH=1 build.
module tb_gate_seq_arbiter;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req0_valid = 1'b0, req1_valid = 1'b0;
  logic        req0_ready, req1_ready;
  logic [1:0]  req0_op = 2'b00, req1_op = 2'b00;
  logic [15:0] req0_a = '0, req0_b = '0, req1_a = '0, req1_b = '0;
  logic        rsp_valid, rsp_ready = 1'b1, rsp_id;
  logic [15:0] rsp_data;
  logic        gate_en, gate_a, gate_b, gate_out;
  logic [1:0]  gate_op;

  logic        w1_req0_valid = 1'b0, w1_req1_valid = 1'b0;
  logic        w1_req0_ready, w1_req1_ready;
  logic [1:0]  w1_req0_op = 2'b00, w1_req1_op = 2'b00;
  logic [0:0]  w1_req0_a = '0, w1_req0_b = '0, w1_req1_a = '0, w1_req1_b = '0;
  logic        w1_rsp_valid, w1_rsp_ready = 1'b1, w1_rsp_id;
  logic [0:0]  w1_rsp_data;
  logic        w1_gate_en, w1_gate_a, w1_gate_b, w1_gate_out;
  logic [1:0]  w1_gate_op;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  function automatic logic gate_f(input logic [1:0] op, input logic a, input logic b);
    case (op)
      2'b00:   return ~(a & b);
      2'b01:   return ~a;
      2'b10:   return a & b;
      default: return a | b;
    endcase
  endfunction

  assign gate_out    = gate_f(gate_op, gate_a, gate_b);
  assign w1_gate_out = gate_f(w1_gate_op, w1_gate_a, w1_gate_b);

  gate_seq_arbiter #(.WIDTH(16)) u_dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_op(req0_op), .req0_a(req0_a), .req0_b(req0_b),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_op(req1_op), .req1_a(req1_a), .req1_b(req1_b),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id), .rsp_data(rsp_data),
    .gate_en(gate_en), .gate_op(gate_op), .gate_a(gate_a), .gate_b(gate_b), .gate_out(gate_out)
  );

  gate_seq_arbiter #(.WIDTH(1)) u_dut_w1 (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(w1_req0_valid), .req0_ready(w1_req0_ready), .req0_op(w1_req0_op), .req0_a(w1_req0_a), .req0_b(w1_req0_b),
    .req1_valid(w1_req1_valid), .req1_ready(w1_req1_ready), .req1_op(w1_req1_op), .req1_a(w1_req1_a), .req1_b(w1_req1_b),
    .rsp_valid(w1_rsp_valid), .rsp_ready(w1_rsp_ready), .rsp_id(w1_rsp_id), .rsp_data(w1_rsp_data),
    .gate_en(w1_gate_en), .gate_op(w1_gate_op), .gate_a(w1_gate_a), .gate_b(w1_gate_b), .gate_out(w1_gate_out)
  );

  typedef struct {
    logic        v0, v1;
    logic [1:0]  op0, op1;
    logic [15:0] a0, b0, a1, b1;
    logic        exp_id;
    logic [15:0] exp_data;
  } vec_t;

  vec_t vecs[8];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Entered and left at #1 after a rising edge with the DUT in IDLE.
  task automatic run_vec(input vec_t v);
    logic [15:0] ga, gb;
    logic [1:0]  gop;
    int          bad;
    req0_valid = v.v0; req0_op = v.op0; req0_a = v.a0; req0_b = v.b0;
    req1_valid = v.v1; req1_op = v.op1; req1_a = v.a1; req1_b = v.b1;
    #1;
    chk("req0_ready", req0_ready, v.exp_id == 1'b0);
    chk("req1_ready", req1_ready, v.exp_id == 1'b1);
    gop = v.exp_id ? v.op1 : v.op0;
    ga  = v.exp_id ? v.a1  : v.a0;
    gb  = v.exp_id ? v.b1  : v.b0;
    @(posedge clk); #1;
    req0_valid = 1'b0; req1_valid = 1'b0;
    bad = 0;
    for (int i = 0; i < 16; i++) begin
      if (gate_en !== 1'b1 || gate_op !== gop || gate_a !== ga[i] || gate_b !== gb[i] ||
          rsp_valid !== 1'b0 || req0_ready !== 1'b0 || req1_ready !== 1'b0) bad++;
      @(posedge clk); #1;
    end
    chk("gate_seq_bad_cycles", bad, 0);
    chk("rsp_valid_latency", rsp_valid, 1'b1);
    chk("rsp_data", rsp_data, v.exp_data);
    chk("rsp_id", rsp_id, v.exp_id);
    chk("gate_en_done", gate_en, 1'b0);
    @(posedge clk); #1;
    chk("rsp_valid_drop", rsp_valid, 1'b0);
  endtask

  initial begin
    vecs[0] = '{1, 1, 2'b11, 2'b00, 16'h00FF, 16'h0F00, 16'hFFFF, 16'h00FF, 1'b0, 16'h0FFF};
    vecs[1] = '{1, 1, 2'b11, 2'b00, 16'h00FF, 16'h0F00, 16'hFFFF, 16'h00FF, 1'b1, 16'hFF00};
    vecs[2] = '{1, 1, 2'b11, 2'b00, 16'h00FF, 16'h0F00, 16'hFFFF, 16'h00FF, 1'b0, 16'h0FFF};
    vecs[3] = '{0, 1, 2'b00, 2'b01, 16'h0000, 16'h0000, 16'h1234, 16'hFFFF, 1'b1, 16'hEDCB};
    vecs[4] = '{1, 0, 2'b10, 2'b00, 16'hF0F0, 16'hFF00, 16'h0000, 16'h0000, 1'b0, 16'hF000};
    vecs[5] = '{1, 0, 2'b00, 2'b00, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 1'b0, 16'hFFFF};
    vecs[6] = '{0, 1, 2'b00, 2'b11, 16'h0000, 16'h0000, 16'h8001, 16'h0000, 1'b1, 16'h8001};
    vecs[7] = '{1, 1, 2'b10, 2'b01, 16'hFFFF, 16'h1234, 16'h0000, 16'h0000, 1'b0, 16'h1234};

    #12;
    chk("reset_rsp_valid", rsp_valid, 1'b0);
    chk("reset_rsp_data", rsp_data, 16'h0);
    chk("reset_gate_en", gate_en, 1'b0);
    chk("reset_rsp_id", rsp_id, 1'b0);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;

    for (int k = 0; k < 8; k++) run_vec(vecs[k]);

    // Backpressure: req0 result held in DONE while req1 waits.
    rsp_ready = 1'b0;
    req0_valid = 1'b1; req0_op = 2'b10; req0_a = 16'hF0F0; req0_b = 16'hFF00;
    #1 chk("bp_req0_ready", req0_ready, 1'b1);
    @(posedge clk); #1;
    req0_valid = 1'b0;
    req1_valid = 1'b1; req1_op = 2'b01; req1_a = 16'h0000; req1_b = 16'h0000;
    repeat (16) @(posedge clk);
    #1;
    for (int i = 0; i < 5; i++) begin
      chk("bp_rsp_valid", rsp_valid, 1'b1);
      chk("bp_rsp_data", rsp_data, 16'hF000);
      chk("bp_rsp_id", rsp_id, 1'b0);
      chk("bp_req1_ready", req1_ready, 1'b0);
      @(posedge clk); #1;
    end
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    chk("bp_after_rsp_valid", rsp_valid, 1'b0);
    chk("bp_after_req1_ready", req1_ready, 1'b1);
    @(posedge clk); #1;
    req1_valid = 1'b0;
    chk("bp_req1_running", gate_en, 1'b1);
    repeat (16) @(posedge clk);
    #1;
    chk("bp_req1_rsp_valid", rsp_valid, 1'b1);
    chk("bp_req1_rsp_data", rsp_data, 16'hFFFF);
    chk("bp_req1_rsp_id", rsp_id, 1'b1);
    @(posedge clk); #1;

    // Reset asserted after RUN bit 7 drops the operation.
    req0_valid = 1'b1; req0_op = 2'b11; req0_a = 16'h0000; req0_b = 16'hFFFF;
    @(posedge clk); #1;
    req0_valid = 1'b0;
    repeat (8) @(posedge clk);
    #2 rst_n = 1'b0;
    req1_valid = 1'b1; req1_op = 2'b10; req1_a = 16'hAAAA; req1_b = 16'hFFFF;
    #1;
    chk("rst_gate_en", gate_en, 1'b0);
    chk("rst_gate_op", gate_op, 2'b00);
    chk("rst_gate_b", gate_b, 1'b0);
    chk("rst_rsp_valid", rsp_valid, 1'b0);
    chk("rst_rsp_data", rsp_data, 16'h0);
    chk("rst_req1_ready", req1_ready, 1'b0);
    @(negedge clk); rst_n = 1'b1;
    #1 chk("post_rst_req1_ready", req1_ready, 1'b1);
    @(posedge clk); #1;
    req1_valid = 1'b0;
    begin
      int stray = 0;
      for (int i = 0; i < 16; i++) begin
        if (rsp_valid !== 1'b0) stray++;
        @(posedge clk); #1;
      end
      chk("post_rst_no_stray_rsp", stray, 0);
    end
    chk("post_rst_rsp_valid", rsp_valid, 1'b1);
    chk("post_rst_rsp_data", rsp_data, 16'hAAAA);
    chk("post_rst_rsp_id", rsp_id, 1'b1);
    @(posedge clk); #1;

    // WIDTH=1 instance: single RUN cycle.
    w1_req0_valid = 1'b1; w1_req0_op = 2'b11; w1_req0_a = 1'b0; w1_req0_b = 1'b1;
    #1 chk("w1_req0_ready", w1_req0_ready, 1'b1);
    @(posedge clk); #1;
    w1_req0_valid = 1'b0;
    chk("w1_gate_en", w1_gate_en, 1'b1);
    chk("w1_gate_b", w1_gate_b, 1'b1);
    chk("w1_rsp_valid_early", w1_rsp_valid, 1'b0);
    @(posedge clk); #1;
    chk("w1_rsp_valid", w1_rsp_valid, 1'b1);
    chk("w1_rsp_data", w1_rsp_data, 1'b1);
    chk("w1_rsp_id", w1_rsp_id, 1'b0);
    chk("w1_gate_en_done", w1_gate_en, 1'b0);
    @(posedge clk); #1;
    chk("w1_rsp_valid_drop", w1_rsp_valid, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, got timeout required completion");
    $fatal(1);
  end

endmodule
